// File: rtl/approx_error_monitor.sv
// approx_error_monitor
// Watches an approximate adder. For each accepted operand set it computes the
// exact sum, then one cycle later compares it with the adder's registered
// output. Over a window of N samples it accumulates the error count, the sum
// of error distances and the largest error distance.
module approx_error_monitor #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [CNT_W-1:0]         num_samples,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         X,
   input  logic [WIDTH-1:0]         Y,
   input  logic                     Cin,
   input  logic [WIDTH:0]           approx_sum,
   output logic                     busy,
   output logic                     done,
   output logic [CNT_W-1:0]         err_count,
   output logic [CNT_W+WIDTH:0]     sum_ed,
   output logic [WIDTH:0]           max_ed
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Exact-sum stage that lines up with the adder's single output register.
   typedef struct packed {
      logic             vld;
      logic [WIDTH:0]   exact;
   } stage_t;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] n_q;
   logic [CNT_W-1:0] issued;
   logic [CNT_W-1:0] compared;
   stage_t           stg;

   logic             arm;
   logic             accept;
   logic             cmp_last;
   logic [WIDTH:0]   exact_nxt;
   logic [WIDTH:0]   ed;

   // A start is only honoured while not measuring.
   assign arm      = start && (state != RUN);
   assign in_ready = (state == RUN) && (issued < n_q);
   assign accept   = in_valid && in_ready;

   // Full-width exact sum, carry-out kept in the top bit.
   assign exact_nxt = {1'b0, X} + {1'b0, Y} + {{WIDTH{1'b0}}, Cin};

   // Unsigned distance between the exact and approximate results.
   always_comb begin
      ed = '0;
      if (stg.exact >= approx_sum)
         ed = stg.exact - approx_sum;
      else
         ed = approx_sum - stg.exact;
   end

   // The last compare of the window closes it on the same edge.
   assign cmp_last = stg.vld && (compared + {{(CNT_W-1){1'b0}}, 1'b1} == n_q);

   // Next-state decode for the window FSM.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (start)
               state_nxt = (num_samples != '0) ? RUN : DONE;
         end
         RUN: begin
            if (cmp_last)
               state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register with registered status flags derived from next state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == RUN);
         done  <= (state_nxt == DONE);
      end
   end

   // Window length and issue counter; the issue side stops at N.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         n_q    <= '0;
         issued <= '0;
      end else if (arm) begin
         n_q    <= num_samples;
         issued <= '0;
      end else if (accept) begin
         issued <= issued + 1'b1;
      end
   end

   // Exact-sum stage: loaded on accept, dropped on a new window.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stg <= '0;
      end else if (arm) begin
         stg.vld <= 1'b0;
      end else begin
         stg.vld <= accept;
         if (accept)
            stg.exact <= exact_nxt;
      end
   end

   // Result accumulators, updated only at the compare stage.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         compared  <= '0;
         err_count <= '0;
         sum_ed    <= '0;
         max_ed    <= '0;
      end else if (arm) begin
         compared  <= '0;
         err_count <= '0;
         sum_ed    <= '0;
         max_ed    <= '0;
      end else if (stg.vld) begin
         compared  <= compared + 1'b1;
         sum_ed    <= sum_ed + {{CNT_W{1'b0}}, ed};
         if (ed != '0)
            err_count <= err_count + 1'b1;
         if (ed > max_ed)
            max_ed <= ed;
      end
   end

endmodule

// File: tb/tb_approx_error_monitor.sv
// Bench for approx_error_monitor: a behavioural window model plus an adder
// model driving approx_sum, a per-cycle compare process, directed scenarios
// with literal expectations, and randomized windows.
module tb_approx_error_monitor;
   localparam int WIDTH = 8;
   localparam int CNT_W = 16;

   logic                 clock = 1'b0;
   logic                 reset = 1'b0;
   logic                 start = 1'b0;
   logic [CNT_W-1:0]     num_samples = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [WIDTH-1:0]     X = '0;
   logic [WIDTH-1:0]     Y = '0;
   logic                 Cin = 1'b0;
   logic [WIDTH:0]       approx_sum = '0;
   logic                 busy;
   logic                 done;
   logic [CNT_W-1:0]     err_count;
   logic [CNT_W+WIDTH:0] sum_ed;
   logic [WIDTH:0]       max_ed;

   int checks = 0;
   int errors = 0;

   approx_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .X(X), .Y(Y), .Cin(Cin),
      .approx_sum(approx_sum), .busy(busy), .done(done),
      .err_count(err_count), .sum_ed(sum_ed), .max_ed(max_ed)
   );

   always #5 clock = ~clock;

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Approximate adder: carry chain cut between bit 3 and bit 4.
   int             amode = 0;
   logic [WIDTH:0] aforce = '0;

   function automatic logic [WIDTH:0] seg_add(logic [7:0] x, logic [7:0] y, logic c);
      logic [4:0] lo;
      logic [4:0] hi;
      lo = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'd0, c};
      hi = {1'b0, x[7:4]} + {1'b0, y[7:4]};
      return {hi, lo[3:0]};
   endfunction

   always @(posedge clock) begin
      case (amode)
         0: approx_sum <= seg_add(X, Y, Cin);
         1: approx_sum <= {1'b0, X} + {1'b0, Y} + {8'd0, Cin};
         2: approx_sum <= 9'($urandom_range(0, 511));
         default: approx_sum <= aforce;
      endcase
   end

   // Behavioural model: window bookkeeping in plain integers.
   bit     m_measuring = 0;
   bit     m_finished  = 0;
   longint m_n = 0, m_iss = 0, m_cmp = 0, m_err = 0, m_sum = 0, m_max = 0;
   bit     m_pend = 0;
   longint m_pexact = 0;

   always @(posedge clock or posedge reset) begin
      bit     was_run;
      bit     acc;
      longint ed;
      if (reset) begin
         m_measuring = 0; m_finished = 0;
         m_n = 0; m_iss = 0; m_cmp = 0; m_err = 0; m_sum = 0; m_max = 0;
         m_pend = 0;
      end else begin
         was_run = m_measuring;
         acc = m_measuring && (m_iss < m_n) && in_valid;
         if (m_pend) begin
            ed = m_pexact - longint'(approx_sum);
            if (ed < 0) ed = -ed;
            m_sum += ed;
            if (ed > m_max) m_max = ed;
            if (ed != 0) m_err++;
            m_cmp++;
            if (m_cmp == m_n) begin
               m_measuring = 0;
               m_finished  = 1;
            end
         end
         m_pend = 0;
         if (start && !was_run) begin
            m_n = num_samples; m_iss = 0; m_cmp = 0;
            m_err = 0; m_sum = 0; m_max = 0;
            m_measuring = (m_n != 0);
            m_finished  = (m_n == 0);
         end else if (acc) begin
            m_pexact = longint'(X) + longint'(Y) + longint'(Cin);
            m_pend = 1;
            m_iss++;
         end
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clock) begin
      chk("busy", busy, m_measuring);
      chk("done", done, m_finished);
      chk("in_ready", in_ready, m_measuring && (m_iss < m_n));
      chk("err_count", err_count, m_err);
      chk("sum_ed", sum_ed, m_sum);
      chk("max_ed", max_ed, m_max);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic do_start(input int n);
      start = 1'b1;
      num_samples = CNT_W'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic c);
      in_valid = 1'b1; X = x; Y = y; Cin = c;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input int limit);
      int cyc;
      cyc = 0;
      while (!done && cyc < limit) begin
         tick();
         cyc++;
      end
      if (!done) chk({name, "_timeout"}, 0, 1);
   endtask

   task automatic chk_results(input string name, input longint e, input longint s, input longint m);
      chk({name, "_err"}, err_count, e);
      chk({name, "_sum"}, sum_ed, s);
      chk({name, "_max"}, max_ed, m);
   endtask

   initial begin
      int rdy_cnt;
      int cyc;
      bit did_rst;

      // Reset behaviour
      #1 reset = 1'b1;
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", in_ready, 0);
      chk_results("rst", 0, 0, 0);
      tick();

      // Three-sample window with the segmented adder
      amode = 0;
      do_start(3);
      in_valid = 1'b1;
      X = 8'h0F; Y = 8'h01; Cin = 1'b0; tick();
      X = 8'h03; Y = 8'h04; Cin = 1'b0; tick();
      X = 8'hFF; Y = 8'hFF; Cin = 1'b1; tick();
      in_valid = 1'b0;
      chk("w3_not_done_early", done, 0);
      wait_done("w3", 10);
      chk("w3_done", done, 1);
      chk_results("w3", 2, 32, 16);
      chk("w3_model_sum", m_sum, 32);
      chk("w3_model_max", m_max, 16);
      tick();

      // Zero-length window goes straight to done
      do_start(0);
      chk("n0_done", done, 1);
      chk("n0_busy", busy, 0);
      chk("n0_ready", in_ready, 0);
      chk_results("n0", 0, 0, 0);
      tick();
      chk("n0_ready_later", in_ready, 0);

      // in_valid held for 5 cycles, only 2 taken
      do_start(2);
      rdy_cnt = 0;
      in_valid = 1'b1;
      repeat (5) begin
         X = 8'($urandom); Y = 8'($urandom); Cin = 1'($urandom);
         if (in_ready) rdy_cnt++;
         tick();
      end
      in_valid = 1'b0;
      chk("n2_ready_cycles", rdy_cnt, 2);
      chk("n2_model_issued", m_iss, 2);
      wait_done("n2", 10);
      chk("n2_done", done, 1);

      // Reset in the middle of a window
      do_start(4);
      in_valid = 1'b1;
      X = 8'h10; Y = 8'h22; Cin = 1'b0; tick();
      X = 8'h33; Y = 8'h44; Cin = 1'b1; tick();
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_ready", in_ready, 0);
      chk_results("mid_rst", 0, 0, 0);
      tick();
      reset = 1'b0;
      tick();
      chk("mid_rst_idle_busy", busy, 0);
      amode = 3; aforce = '0;
      do_start(1);
      send(8'h08, 8'h00, 1'b0);
      wait_done("after_rst", 10);
      chk_results("after_rst", 1, 8, 8);

      // Restart from done clears results before the new sample
      amode = 0;
      do_start(1);
      chk_results("restart_clr", 0, 0, 0);
      chk("restart_busy", busy, 1);
      send(8'h01, 8'h01, 1'b0);
      wait_done("restart", 10);
      chk_results("restart", 0, 0, 0);
      tick();

      // Randomized windows
      for (int w = 0; w < 25; w++) begin
         amode = $urandom_range(0, 2);
         do_start($urandom_range(0, 8));
         cyc = 0;
         did_rst = 0;
         while (!done && cyc < 200) begin
            if ((w % 7) == 3 && cyc == 2) begin
               in_valid = 1'b0;
               reset = 1'b1;
               tick();
               reset = 1'b0;
               did_rst = 1;
               break;
            end
            in_valid = ($urandom_range(0, 9) < 7);
            X = 8'($urandom); Y = 8'($urandom); Cin = 1'($urandom);
            start = ($urandom_range(0, 19) == 0);
            num_samples = CNT_W'($urandom_range(0, 8));
            tick();
            start = 1'b0;
            cyc++;
         end
         in_valid = 1'b0;
         if (!did_rst) chk("rand_done", done, 1);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
